// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes enter a small FIFO through a valid/ready
// handshake and leave LSB-first as 8N1 frames at clk_freq / uart_baud_rate cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned clk_freq       = 100000000,
  parameter int unsigned uart_baud_rate = 1152000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       busy
);

  localparam int unsigned DIVISOR = clk_freq / uart_baud_rate;
  localparam int unsigned CntW    = $clog2(DIVISOR);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW  = PtrW + 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(DIVISOR - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_nonempty;

  // Pushes are only offered while the registered ready is high, so a full FIFO never accepts.
  assign push          = tx_valid & ready_q;
  assign bit_end       = (cnt_q == CntLast);
  assign fifo_nonempty = (count_q != '0);

  assign tx_ready = ready_q;
  assign uart_txd = txd_q;
  assign busy     = busy_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition out of a bit state happens at the end of a bit period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fifo_nonempty) state_d = StStart;
      StStart:  if (bit_end) state_d = StData;
`ifdef UART_TX_PARITY_EN
      StData:   if (bit_end && bit_q == 3'd7) state_d = StParity;
      StParity: if (bit_end) state_d = StStop;
`else
      StData:   if (bit_end && bit_q == 3'd7) state_d = StStop;
`endif
      StStop:   if (bit_end) state_d = fifo_nonempty ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-state: line level, shift register, bit/divisor counters, pops.
  always_comb begin
    pop     = 1'b0;
    txd_d   = txd_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    // Counter restarts at every bit boundary and stays parked at zero while idle.
    cnt_d = (state_q == StIdle || bit_end) ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop   = 1'b1;
          txd_d = 1'b0;
          bit_d = 3'd0;
        end
      end
      StStart: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d = parity_q;
`else
            txd_d = 1'b1;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) txd_d = 1'b1;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (fifo_nonempty) begin
            // Chain straight into the next start bit with no idle gap.
            pop   = 1'b1;
            txd_d = 1'b0;
            bit_d = 3'd0;
          end else begin
            txd_d = 1'b1;
          end
        end
      end
      default: txd_d = 1'b1;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CountW'(push) - CountW'(pop);
    ready_d  = (count_d != CountFull);
    busy_d   = (state_d != StIdle) || (count_d != '0);
  end

  // Datapath and control registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: one default-divisor instance (86) and one fast
// instance (divisor 10) sharing a clock, with a line receiver on the fast instance.
module tb_uart_tx_fifo;

  localparam int DDIV = 86;
  localparam int FDIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       d_rst, d_valid, d_ready, d_txd, d_busy;
  logic [7:0] d_data;
  logic       f_rst, f_valid, f_ready, f_txd, f_busy;
  logic [7:0] f_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  uart_tx_fifo d_dut (
    .clk      (clk),
    .rst      (d_rst),
    .tx_data  (d_data),
    .tx_valid (d_valid),
    .tx_ready (d_ready),
    .uart_txd (d_txd),
    .busy     (d_busy)
  );

  uart_tx_fifo #(
    .clk_freq       (1000000),
    .uart_baud_rate (100000),
    .FIFO_DEPTH     (4)
  ) f_dut (
    .clk      (clk),
    .rst      (f_rst),
    .tx_data  (f_data),
    .tx_valid (f_valid),
    .tx_ready (f_ready),
    .uart_txd (f_txd),
    .busy     (f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver on the fast instance, sampling mid-bit on the falling edge.
  logic       rx_en = 1'b0;
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_err = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  always @(negedge clk) begin
    if (!rx_en) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (f_txd === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % FDIV == FDIV / 2) begin
        if (rx_cnt / FDIV == 0) begin
          if (f_txd !== 1'b0) rx_err <= rx_err + 1;
        end else if (rx_cnt / FDIV <= 8) begin
          rx_sh <= {f_txd, rx_sh[7:1]};
`ifdef UART_TX_PARITY_EN
        end else if (rx_cnt / FDIV == 9) begin
          if (f_txd !== ^rx_sh) rx_err <= rx_err + 1;
`endif
        end else begin
          if (f_txd !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(rx_sh);
          rx_act <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; returns at #1 after the accepting edge.
  task automatic push(input bit fast, input logic [7:0] b);
    int guard = 0;
    if (fast) begin f_data = b; f_valid = 1'b1; end
    else begin d_data = b; d_valid = 1'b1; end
    while (!(fast ? f_ready : d_ready) && guard < 2000) begin
      tick();
      guard++;
    end
    check("push_ready", fast ? f_ready : d_ready, 1);
    tick();
    if (fast) f_valid = 1'b0;
    else d_valid = 1'b0;
  endtask

  // Starting at #1 after the edge that began the start bit, compare every cycle of the frame.
  task automatic watch_frame(input bit fast, input logic [10:0] seq,
                             output int errs, output int busy_errs);
    int d;
    d = fast ? FDIV : DDIV;
    errs = 0;
    busy_errs = 0;
    for (int c = 0; c < FB * d; c++) begin
      if ((fast ? f_txd : d_txd) !== seq[c / d]) errs++;
      if ((fast ? f_busy : d_busy) !== 1'b1) busy_errs++;
      tick();
    end
  endtask

  task automatic wait_fast_idle(input int budget, output int fall_cyc);
    int n = 0;
    while (f_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", f_busy, 0);
    fall_cyc = cyc;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit 0 first on the wire: start, d0..d7, stop
    logic       par;   // even parity of data
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [10:0] seq;
    int errs, berrs, fall, err0, mism;
    int acc[6];
    logic [7:0] burst[6];
    int idx, guard;
    logic pre;
    bit stuck;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h41, 10'b1010000010, 1'b0};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[5] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[6] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[7] = '{8'h03, 10'b1000000110, 1'b0};
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
    burst[3] = 8'hAA; burst[4] = 8'h0F; burst[5] = 8'h33;

    d_rst = 1'b1; f_rst = 1'b1;
    d_valid = 1'b0; f_valid = 1'b0;
    d_data = 8'h00; f_data = 8'h00;

    // Reset state, then ready rises one edge after reset drops.
    repeat (3) tick();
    check("rst_d_txd", d_txd, 1);
    check("rst_d_busy", d_busy, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_f_txd", f_txd, 1);
    check("rst_f_busy", f_busy, 0);
    check("rst_f_ready", f_ready, 0);
    d_rst = 1'b0; f_rst = 1'b0;
    tick();
    check("post_rst_d_ready", d_ready, 1);
    check("post_rst_f_ready", f_ready, 1);
    check("post_rst_f_busy", f_busy, 0);

    // Default divisor: 0x41, every bit 86 cycles.
    push(1'b0, 8'h41);
    check("def_latency", d_txd, 1);
    tick();
    watch_frame(1'b0, {1'b1, 10'b1010000010}, errs, berrs);
    check("def_frame_0x41", errs, 0);
    check("def_busy_in_frame", berrs, 0);
    check("def_busy_after", d_busy, 0);

    // Table: single frames on the fast instance.
    foreach (vecs[i]) begin
`ifdef UART_TX_PARITY_EN
      seq = {vecs[i].line[9], vecs[i].par, vecs[i].line[8:0]};
`else
      seq = {1'b1, vecs[i].line};
`endif
      push(1'b1, vecs[i].data);
      check($sformatf("latency_%02h", vecs[i].data), f_txd, 1);
      tick();
      watch_frame(1'b1, seq, errs, berrs);
      check($sformatf("frame_%02h", vecs[i].data), errs, 0);
      check($sformatf("busy_in_frame_%02h", vecs[i].data), berrs, 0);
      check($sformatf("busy_fall_%02h", vecs[i].data), f_busy, 0);
      check($sformatf("line_idle_%02h", vecs[i].data), f_txd, 1);
    end

    // Burst of six with tx_valid held high.
    repeat (3) tick();
    rx_q.delete();
    rx_start_q.delete();
    err0 = rx_err;
    rx_en = 1'b1;
    idx = 0;
    guard = 0;
    f_data = burst[0];
    f_valid = 1'b1;
    while (idx < 6 && guard < 2000) begin
      pre = f_ready;
      tick();
      guard++;
      if (pre) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 6) f_data = burst[idx];
        else f_valid = 1'b0;
        if (idx == 5) check("burst_full_ready", f_ready, 0);
      end
    end
    f_valid = 1'b0;
    check("burst_accepts", idx, 6);
    if (idx == 6) begin
      mism = 0;
      for (int k = 1; k < 5; k++) if (acc[k] - acc[0] != k) mism++;
      check("burst_consecutive", mism, 0);
      check("burst_sixth_accept", acc[5] - acc[0], 2 + FB * FDIV);
    end
    wait_fast_idle(8 * FB * FDIV, fall);
    repeat (5) tick();
    rx_en = 1'b0;
    check("burst_frames", rx_q.size(), 6);
    if (rx_q.size() == 6 && rx_start_q.size() == 6) begin
      mism = 0;
      for (int k = 0; k < 6; k++) begin
        if (rx_q[k] !== burst[k]) mism++;
        if (rx_start_q[k] - rx_start_q[0] != k * FB * FDIV) mism++;
      end
      check("burst_order_gapless", mism, 0);
      check("burst_first_start", rx_start_q[0], acc[0] + 1);
      check("burst_busy_fall", fall, rx_start_q[0] + 6 * FB * FDIV);
    end
    check("burst_rx_errors", rx_err - err0, 0);

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    repeat (3) tick();
    push(1'b1, 8'hC3);
    push(1'b1, 8'h11);
    push(1'b1, 8'h22);
    repeat (43) tick();
    check("midframe_bit3", f_txd, 0);
    check("midframe_busy", f_busy, 1);
    f_rst = 1'b1;
    tick();
    check("abort_txd", f_txd, 1);
    check("abort_busy", f_busy, 0);
    check("abort_ready_in_rst", f_ready, 0);
    f_rst = 1'b0;
    tick();
    check("abort_ready_after", f_ready, 1);
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      if (f_txd !== 1'b1 || f_busy !== 1'b0) errs++;
      tick();
    end
    check("abort_quiet", errs, 0);

    // 256 bytes with random valid gaps and junk data outside handshakes.
    rx_q.delete();
    rx_start_q.delete();
    err0 = rx_err;
    rx_en = 1'b1;
    stuck = 1'b0;
    for (int b = 0; b < 256 && !stuck; b++) begin
      guard = 0;
      pre = 1'b0;
      while (!pre && guard < 5000) begin
        f_valid = ($urandom_range(0, 3) != 0);
        f_data = f_valid ? 8'(b) : 8'($urandom_range(0, 255));
        pre = f_valid && f_ready;
        tick();
        guard++;
      end
      if (!pre) stuck = 1'b1;
    end
    f_valid = 1'b0;
    check("stall_push_progress", stuck, 0);
    wait_fast_idle(260 * FB * FDIV, fall);
    repeat (5) tick();
    rx_en = 1'b0;
    check("stall_count", rx_q.size(), 256);
    mism = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) mism++;
    check("stall_order", mism, 0);
    check("stall_rx_errors", rx_err - err0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter. Serializes bytes onto a UART line for the receive side of the system UART (drives the system's uart_rxd).
- Used in the system testbench as the simulated comm partner. It is also synthesizable as the standalone transmit path of the SoC UART.
- Bytes enter through a valid/ready handshake into a small FIFO and are sent LSB-first with a fixed baud divisor.

Parameters:
- clk_freq, 100000000, system clock frequency in Hz.
- uart_baud_rate, 1152000, line bit rate.
- FIFO_DEPTH, 4, byte entries. Must be a power of 2 and at least 2.
- DIVISOR = clk_freq / uart_baud_rate, integer division. This is a localparam, must be at least 2, and equals 86 at defaults.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  8  byte to send. Sampled only on an accepting edge.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  FIFO can accept. Handshake completes when tx_valid and tx_ready are both high at a rising edge.
- uart_txd  out  1  serial line, idle high.
- busy  out  1  FIFO non-empty or frame in progress.

Behaviour:
- Reset values, taken one edge after rst is sampled high:
  - uart_txd=1, busy=0, FIFO count=0, state IDLE, divisor counter=0.
  - tx_ready=0 while rst is high. It becomes 1 on the first edge after rst falls.
- tx_ready is registered: tx_ready = (count != FIFO_DEPTH).
  - A pop and a push in the same cycle leave count unchanged.
  - When full, a push is refused even if a pop occurs that same cycle.
- FIFO ordering: strict first-in first-out, with no drop and no duplication.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- States: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
  - IDLE: if the FIFO is non-empty, pop into the shift register, drive uart_txd=0, clear the bit counter, go to START.
  - START: hold for DIVISOR cycles, then output bit0 and go to DATA.
  - DATA: each bit is held DIVISOR cycles, LSB first. After bit7's period, drive 1 and go to STOP.
  - STOP: hold 1 for DIVISOR cycles. At the end, if the FIFO is non-empty, pop and go directly to START with uart_txd=0. Otherwise go to IDLE.
- Bit timing: the divisor counter runs 0..DIVISOR-1 and is cleared on every state transition. A bit ends when the counter equals DIVISOR-1. Counter width is clog2(DIVISOR).
- Latency: a byte accepted at edge N into an empty, idle block drives uart_txd low after edge N+1.
- Back-to-back frames have zero idle cycles between a stop bit and the next start bit.
- Frame length is 10*DIVISOR cycles.
- busy = (state != IDLE) or (count != 0). It is registered and falls on the edge the block enters IDLE with an empty FIFO.
- tx_data and tx_valid changes outside a handshake have no effect.
- Reset mid-frame: the frame is aborted, uart_txd=1 on the next edge, and the FIFO is flushed. No partial frame resumes after reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA and STOP.
  - The bit equals the XOR of the 8 data bits and is held DIVISOR cycles in state PARITY.
  - Frame becomes 11*DIVISOR cycles.
- Undefined: the PARITY state and its logic are absent. Frames are 8N1, 10*DIVISOR cycles.

Test Plan:
1. Defaults, single byte:
   - clk_freq=100000000, uart_baud_rate=1152000, push 0x41.
   - Each bit held exactly 86 cycles. Line pattern 0,1,0,0,0,0,0,1,0,1.
2. Single byte, fast divisor:
   - clk_freq=1000000, uart_baud_rate=100000 (DIVISOR=10), push 0xA5 at edge N.
   - uart_txd low from edge N+1 for 10 cycles, then 1,0,1,0,0,1,0,1, then stop high for 10 cycles.
   - busy falls 100 cycles after the start bit began.
3. Burst, DIVISOR=10, FIFO_DEPTH=4:
   - tx_valid held high with 0x00,0xFF,0x55,0xAA,0x0F,0x33.
   - First five accepted on consecutive edges. tx_ready is 0 while the FIFO holds four bytes, and 0x33 is accepted on the edge after the first frame's end pop.
   - Six contiguous frames in order over 600 cycles, with no idle gap.
4. Reset mid-frame:
   - Assert rst for 1 cycle during data bit 3 of 0xC3, with 2 bytes queued.
   - uart_txd=1 the next edge, busy=0, tx_ready=0 during rst then 1.
   - No further line activity.
5. Stall integrity:
   - Random tx_valid and 256 bytes 0x00..0xFF with DIVISOR=10.
   - A bench UART receiver decodes exactly 0x00..0xFF in order.
6. With UART_TX_PARITY_EN, DIVISOR=10:
   - 0x07 yields parity bit 1; 0x03 yields parity bit 0.
   - Each frame is 110 cycles.
